// File: rtl/bus_data_ram.sv
// Word-organised data RAM on the core load/store bus, with fixed-latency busy handshake.
// Define RISCUIN_BUS_ERR_EN to flag misaligned, out-of-range, invalid-size or rd+wd requests on err.
module bus_data_ram #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wd,
    input  logic        rd,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [31:0]     data_out_q;
    logic [31:0]     data_out_d;
    logic            err_q;
    logic            err_d;
    logic [31:0]     mem_q [DEPTH];

    logic                  req;
    logic                  access;
    logic                  fault;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           word_rd;
    logic [31:0]           read_val;
    logic [31:0]           wdata;
    logic [31:0]           wmask;

`ifdef RISCUIN_BUS_ERR_EN
    always_comb begin
        fault = (size == 2'b11)
             || ((size == 2'b01) && addr[0])
             || ((size == 2'b10) && (addr[1:0] != 2'b00))
             || ((addr >> (ADDR_WIDTH + 2)) != '0)
             || (rd && wd);
    end
`else
    logic unused_addr_hi;

    assign fault          = 1'b0;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];
`endif

    // Lane steering; size 11 falls through to the word path.
    always_comb begin
        req     = rd | wd;
        idx     = addr[ADDR_WIDTH+1:2];
        lane    = addr[1:0];
        word_rd = mem_q[idx];
        case (size)
            2'b00: begin
                read_val = {24'b0, word_rd[{lane, 3'b000} +: 8]};
                wdata    = {4{data_in[7:0]}};
                wmask    = 32'h0000_00FF << {lane, 3'b000};
            end
            2'b01: begin
                read_val = {16'b0, word_rd[{lane[1], 4'b0000} +: 16]};
                wdata    = {2{data_in[15:0]}};
                wmask    = 32'h0000_FFFF << {lane[1], 4'b0000};
            end
            default: begin
                read_val = word_rd;
                wdata    = data_in;
                wmask    = '1;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            IDLE:    access = req && (WAIT_STATES == 0);
            WAIT:    access = req && (cnt_q == '0);
            default: access = 1'b0;
        endcase
        mem_we     = access && wd && !fault && !rst;
        data_out_d = (access && rd && !wd && !fault) ? read_val : data_out_q;
        err_d      = access && fault;
    end

    // Request cycle raises busy combinationally so the core stalls without a bubble.
    assign busy     = !rst && (((state_q == IDLE) && req) || (state_q == WAIT));
    assign data_out = data_out_q;
    assign err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            err_q      <= err_d;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= 4'(WAIT_STATES - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= (word_rd & ~wmask) | (wdata & wmask);
        end
    end

endmodule

// File: tb/tb_bus_data_ram.sv
// Directed bench for bus_data_ram: unit 0 with one wait state, unit 1 with three.
module tb_bus_data_ram;

    logic        clk;
    logic        rst_v     [2];
    logic        wd_v      [2];
    logic        rd_v      [2];
    logic [1:0]  size_v    [2];
    logic [31:0] addr_v    [2];
    logic [31:0] din_v     [2];
    logic [31:0] dout_v    [2];
    logic        busy_v    [2];
    logic        err_v     [2];

    int n_tests;
    int n_fail;

    bus_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst_v[0]), .wd(wd_v[0]), .rd(rd_v[0]), .size(size_v[0]),
        .addr(addr_v[0]), .data_in(din_v[0]), .data_out(dout_v[0]),
        .busy(busy_v[0]), .err(err_v[0])
    );

    bus_data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst_v[1]), .wd(wd_v[1]), .rd(rd_v[1]), .size(size_v[1]),
        .addr(addr_v[1]), .data_in(din_v[1]), .data_out(dout_v[1]),
        .busy(busy_v[1]), .err(err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic w, input logic r, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        wd_v[u]   = w;
        rd_v[u]   = r;
        size_v[u] = sz;
        addr_v[u] = a;
        din_v[u]  = d;
    endtask

    // One complete access: busy for WAIT_STATES+1 cycles, then the DONE cycle.
    task automatic do_access(input int u, input logic w, input logic r, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_dout, input logic exp_err, input string tag);
        int unsigned ws;
        ws = (u == 0) ? 1 : 3;
        drive(u, w, r, sz, a, d);
        for (int unsigned c = 0; c <= ws; c++) begin
            @(negedge clk);
            chk($sformatf("%s busy%0d", tag, c), 32'(busy_v[u]), 32'd1);
            tick();
        end
        wd_v[u] = 1'b0;
        rd_v[u] = 1'b0;
        @(negedge clk);
        chk({tag, " done_busy"}, 32'(busy_v[u]), 32'd0);
        chk({tag, " dout"}, dout_v[u], exp_dout);
        chk({tag, " err"}, 32'(err_v[u]), 32'(exp_err));
        tick();
    endtask

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

`ifdef RISCUIN_BUS_ERR_EN
    localparam logic        ERR_ON = 1'b1;
`else
    localparam logic        ERR_ON = 1'b0;
`endif

    initial begin
        logic [31:0] ex;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1;
            drive(i, 1'b0, 1'b0, SZ_B, 32'h0, 32'h0);
        end
        rd_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy u0", 32'(busy_v[0]), 32'd0);
        chk("rst dout u0", dout_v[0], 32'h0);
        chk("rst err u0", 32'(err_v[0]), 32'd0);
        chk("rst busy u1", 32'(busy_v[1]), 32'd0);
        chk("rst dout u1", dout_v[1], 32'h0);
        tick();
        rd_v[0]  = 1'b0;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        tick();

        do_access(0, 1, 0, SZ_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "wr10");
        do_access(0, 0, 1, SZ_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "rd10");
        do_access(0, 1, 0, SZ_W, 32'h20, 32'h11223344, 32'hDEADBEEF, 1'b0, "wr20");
        do_access(0, 1, 0, SZ_B, 32'h21, 32'h123456AA, 32'hDEADBEEF, 1'b0, "wb21");
        do_access(0, 0, 1, SZ_W, 32'h20, 32'h0, 32'h1122AA44, 1'b0, "rw20");
        do_access(0, 0, 1, SZ_B, 32'h23, 32'h0, 32'h00000011, 1'b0, "rb23");
        do_access(0, 0, 1, SZ_H, 32'h22, 32'h0, 32'h00001122, 1'b0, "rh22");
        do_access(0, 0, 1, SZ_B, 32'h21, 32'h0, 32'h000000AA, 1'b0, "rb21");
        do_access(0, 1, 0, SZ_H, 32'h12, 32'hFFFFBEEF, 32'h000000AA, 1'b0, "wh12");
        do_access(0, 0, 1, SZ_W, 32'h10, 32'h0, 32'hBEEFBEEF, 1'b0, "rw10");
        do_access(0, 1, 0, SZ_W, 32'h30, 32'h01020304, 32'hBEEFBEEF, 1'b0, "wr30");

        do_access(0, 1, 1, SZ_W, 32'h30, 32'hCAFEF00D, 32'hBEEFBEEF, ERR_ON, "rdwd30");
        ex = ERR_ON ? 32'h01020304 : 32'hCAFEF00D;
        do_access(0, 0, 1, SZ_W, 32'h30, 32'h0, ex, 1'b0, "rw30");
        if (!ERR_ON) ex = 32'h1122AA44;
        do_access(0, 0, 1, SZ_W, 32'h22, 32'h0, ex, ERR_ON, "rw22mis");
        if (!ERR_ON) ex = 32'hBEEFBEEF;
        do_access(0, 0, 1, SZ_W, 32'h1010, 32'h0, ex, ERR_ON, "rwrange");
        if (!ERR_ON) ex = 32'h1122AA44;
        do_access(0, 0, 1, SZ_X, 32'h20, 32'h0, ex, ERR_ON, "rsz11");
        if (!ERR_ON) ex = 32'h0000AA44;
        do_access(0, 0, 1, SZ_H, 32'h21, 32'h0, ex, ERR_ON, "rh21mis");
        @(negedge clk);
        chk("err cleared idle", 32'(err_v[0]), 32'd0);
        tick();

        drive(0, 1'b0, 1'b1, SZ_W, 32'h10, 32'h0);
        @(negedge clk);
        chk("b2b a busy0", 32'(busy_v[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b a busy1", 32'(busy_v[0]), 32'd1);
        tick();
        addr_v[0] = 32'h20;
        @(negedge clk);
        chk("b2b a done_busy", 32'(busy_v[0]), 32'd0);
        chk("b2b a dout", dout_v[0], 32'hBEEFBEEF);
        tick();
        @(negedge clk);
        chk("b2b b busy0", 32'(busy_v[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b b busy1", 32'(busy_v[0]), 32'd1);
        tick();
        rd_v[0] = 1'b0;
        @(negedge clk);
        chk("b2b b done_busy", 32'(busy_v[0]), 32'd0);
        chk("b2b b dout", dout_v[0], 32'h1122AA44);
        tick();
        @(negedge clk);
        chk("b2b idle busy", 32'(busy_v[0]), 32'd0);
        tick();

        do_access(1, 1, 0, SZ_W, 32'h40, 32'h55AA55AA, 32'h0, 1'b0, "u1 wr40");
        drive(1, 1'b1, 1'b0, SZ_W, 32'h40, 32'h12345678);
        @(negedge clk);
        chk("drop busy0", 32'(busy_v[1]), 32'd1);
        tick();
        @(negedge clk);
        chk("drop busy1", 32'(busy_v[1]), 32'd1);
        tick();
        wd_v[1] = 1'b0;
        tick();
        @(negedge clk);
        chk("drop idle busy", 32'(busy_v[1]), 32'd0);
        chk("drop dout", dout_v[1], 32'h0);
        tick();
        do_access(1, 0, 1, SZ_W, 32'h40, 32'h0, 32'h55AA55AA, 1'b0, "u1 rd40 after drop");

        drive(1, 1'b1, 1'b0, SZ_W, 32'h40, 32'h0BADF00D);
        tick();
        tick();
        rst_v[1] = 1'b1;
        #1;
        chk("midrst busy", 32'(busy_v[1]), 32'd0);
        chk("midrst dout", dout_v[1], 32'h0);
        chk("midrst err", 32'(err_v[1]), 32'd0);
        @(negedge clk);
        chk("midrst held busy", 32'(busy_v[1]), 32'd0);
        tick();
        wd_v[1]  = 1'b0;
        rst_v[1] = 1'b0;
        tick();
        do_access(1, 0, 1, SZ_W, 32'h40, 32'h0, 32'h55AA55AA, 1'b0, "u1 rd40 after rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_data_ram.md
BUS_DATA_RAM -- requirements
Module: bus_data_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the word-address width (memory = 2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter WAIT_STATES, default 1, the extra busy cycles per access (legal 0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wd, input, 1, write request from the core bus initiator.
REQ-006 SHALL have port rd, input, 1, read request from the core bus initiator.
REQ-007 SHALL have port size, input, 2, access size: 00 byte, 01 half, 10 word, 11 invalid.
REQ-008 SHALL have port addr, input, 32, byte address.
REQ-009 SHALL have port data_in, input, 32, write data, right-justified.
REQ-010 SHALL have port data_out, output, 32, read data, right-justified and zero-extended.
REQ-011 SHALL have port busy, output, 1, high while an accepted request is incomplete (core stalls its PC).
REQ-012 SHALL have port err, output, 1, access-fault pulse (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 IDLE with rd or wd high: busy SHALL go high combinationally in the same cycle and the request is accepted.
- Accept with WAIT_STATES=0: access at that edge, next state DONE.
- Otherwise: wait counter loaded with WAIT_STATES-1, next state WAIT.
REQ-015 WAIT: busy SHALL stay high; counter decrements each cycle; at counter=0 the access executes at the edge and the FSM goes to DONE.
REQ-016 Busy SHALL be high for exactly WAIT_STATES+1 consecutive cycles per access, starting with the request cycle.
REQ-017 DONE SHALL last one cycle with busy low and data_out valid; the FSM then returns to IDLE unconditionally, and a request present in DONE SHALL NOT be accepted.
REQ-018 The initiator SHALL hold rd, wd, size, addr and data_in stable while busy is high.
REQ-019 If rd and wd both drop during WAIT, the FSM SHALL return to IDLE with no memory write and data_out unchanged.
REQ-020 Reads SHALL select lanes by addr[1:0] (byte) or addr[1] (half) and zero-extend to 32 bits; word reads return the full word.
REQ-021 Writes SHALL update only the addressed byte lanes; other bytes keep their value.
REQ-022 data_out SHALL be registered, update only on completed reads, and hold its value otherwise.
REQ-023 If rd and wd are both high, the write SHALL take priority.
REQ-024 Word index SHALL be addr[ADDR_WIDTH+1:2].

Reset
REQ-025 rst high SHALL immediately force state IDLE, counter 0, data_out 0, busy 0 and err 0.
REQ-026 rst mid-access SHALL abort the access with no memory write.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With RISCUIN_BUS_ERR_EN defined, these requests SHALL complete with normal timing but suppress the memory write and any data_out update, with err high for the DONE cycle only:
- size=11;
- half access with addr[0]=1;
- word access with addr[1:0]!=0;
- addr >= 4*2**ADDR_WIDTH;
- rd and wd both high.
REQ-029 Without RISCUIN_BUS_ERR_EN, err SHALL be tied 0:
- unused low address bits ignored (half forces addr[0]=0, word forces addr[1:0]=0);
- addresses wrap modulo memory size;
- size=11 treated as word.

Verification
REQ-030 WAIT_STATES=1: wd, size=10, addr=0x10, data_in=0xDEADBEEF, then rd, size=10, addr=0x10 -> busy high 2 cycles each; data_out=0xDEADBEEF in DONE.
REQ-031 Word 0x11223344 at 0x20; byte write 0xAA to 0x21; then reads:
- word read -> 0x1122AA44;
- byte read at 0x23 -> 0x00000011;
- half read at 0x22 -> 0x00001122.
REQ-032 WAIT_STATES=3, wd at 0x40 dropped after 2 busy cycles -> FSM returns to IDLE; later read of 0x40 returns the prior contents.
REQ-033 rst asserted in the second WAIT cycle of a write -> busy=0 and data_out=0 immediately; memory word unchanged.
REQ-034 With RISCUIN_BUS_ERR_EN, word read at 0x22 -> err=1 for one cycle, data_out unchanged. Without it, the same read returns the word at 0x20 and err=0.
REQ-035 Back-to-back rd requests with rd held through DONE -> second access accepted only in the following IDLE cycle; busy low exactly one cycle between them.
